// File: rtl/bird_pkg.sv
// Shared definitions for the bird controller: round-state encoding and
// default screen geometry for the bird's vertical position.
package bird_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DEAD = 2'd2
   } bird_state_t;

   localparam logic [9:0] BIRD_Y_INIT = 10'd240;
   localparam logic [9:0] BIRD_Y_MIN  = 10'd0;
   localparam logic [9:0] BIRD_Y_MAX  = 10'd460;

   localparam logic [7:0] SCORE_MAX = 8'd255;

endpackage

// File: rtl/bird_score.sv
// Saturating 8-bit pipe counter with synchronous clear and count enable.
// Clear has priority over enable.
module bird_score
   import bird_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   output logic [7:0] score
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         score <= '0;
      end else if (clr) begin
         score <= '0;
      end else if (en && (score != SCORE_MAX)) begin
         score <= score + 8'd1;
      end
   end

endmodule

// File: rtl/bird_ctrl.sv
// Bird round controller: owns bird Y, IDLE/PLAY/DEAD state and score.
// Define BIRD_SCORE_EN to build the pipe counter; otherwise score is tied to 0.
module bird_ctrl
   import bird_pkg::*;
#(
   parameter int             Y_W       = 10,
   parameter logic [Y_W-1:0] Y_INIT    = Y_W'(BIRD_Y_INIT),
   parameter logic [Y_W-1:0] Y_MIN     = Y_W'(BIRD_Y_MIN),
   parameter logic [Y_W-1:0] Y_MAX     = Y_W'(BIRD_Y_MAX),
   parameter logic [Y_W-1:0] FLAP_STEP = Y_W'(24),
   parameter logic [Y_W-1:0] GRAV_STEP = Y_W'(4)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           up_key_press,
   input  logic           down_key_press,
   input  logic           start,
   input  logic           collide,
   input  logic           pipe_pass,
   output logic [Y_W-1:0] bird_y,
   output logic [1:0]     state,
   output logic           game_over,
   output logic [7:0]     score
);

   bird_state_t    state_p0, state_p1;
   logic [Y_W-1:0] y_p0, y_p1;
   logic           go_p1;
   logic           score_inc, score_clr;

   // Ceiling clamp: compare before subtracting so the coordinate never wraps.
   function automatic logic [Y_W-1:0] sat_flap(input logic [Y_W-1:0] y);
      logic [Y_W:0] lim;
      lim = {1'b0, Y_MIN} + {1'b0, FLAP_STEP};
      if ({1'b0, y} < lim) return Y_MIN;
      return y - FLAP_STEP;
   endfunction

   function automatic logic [Y_W-1:0] sat_grav(input logic [Y_W-1:0] y);
      logic [Y_W:0] sum;
      sum = {1'b0, y} + {1'b0, GRAV_STEP};
      if (sum >= {1'b0, Y_MAX}) return Y_MAX;
      return sum[Y_W-1:0];
   endfunction

   always_comb begin
      state_p0  = state_p1;
      y_p0      = y_p1;
      score_inc = 1'b0;
      score_clr = 1'b0;
      case (state_p1)
         ST_IDLE: begin
            y_p0 = Y_INIT;
            if (start) state_p0 = ST_PLAY;
         end
         ST_PLAY: begin
            score_inc = pipe_pass;
            if (collide) begin
               state_p0 = ST_DEAD;
            end else if (up_key_press) begin
               y_p0 = sat_flap(y_p1);
            end else if (down_key_press) begin
               y_p0 = sat_grav(y_p1);
               if (y_p0 == Y_MAX) state_p0 = ST_DEAD;
            end
         end
         ST_DEAD: begin
            if (start) begin
               state_p0  = ST_IDLE;
               y_p0      = Y_INIT;
               score_clr = 1'b1;
            end
         end
         default: begin
            state_p0  = ST_IDLE;
            y_p0      = Y_INIT;
            score_clr = 1'b1;
         end
      endcase
   end

   // Output registers: state, Y and game_over all update on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_p1 <= ST_IDLE;
         y_p1     <= Y_INIT;
         go_p1    <= 1'b0;
      end else begin
         state_p1 <= state_p0;
         y_p1     <= y_p0;
         go_p1    <= (state_p0 == ST_DEAD);
      end
   end

   assign state     = state_p1;
   assign bird_y    = y_p1;
   assign game_over = go_p1;

`ifdef BIRD_SCORE_EN
   bird_score u_score (
      .clk   (clk),
      .reset (reset),
      .clr   (score_clr),
      .en    (score_inc),
      .score (score)
   );
`else
   logic unused_score_ctl;
   assign unused_score_ctl = ^{pipe_pass, score_inc, score_clr};
   assign score = 8'd0;
`endif

endmodule

// File: tb/tb_bird_ctrl.sv
// Randomised and directed bench for bird_ctrl against a behavioural round model.
module tb_bird_ctrl;

`ifdef BIRD_SCORE_EN
   localparam bit SCORE_EN = 1'b1;
`else
   localparam bit SCORE_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       up_key_press = 1'b0, down_key_press = 1'b0, start = 1'b0;
   logic       collide = 1'b0, pipe_pass = 1'b0;
   logic [9:0] bird_y;
   logic [1:0] state;
   logic       game_over;
   logic [7:0] score;

   int checks = 0;
   int errors = 0;
   int m_st, m_y, m_sc;

   bird_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .up_key_press   (up_key_press),
      .down_key_press (down_key_press),
      .start          (start),
      .collide        (collide),
      .pipe_pass      (pipe_pass),
      .bird_y         (bird_y),
      .state          (state),
      .game_over      (game_over),
      .score          (score)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_st = 0; m_y = 240; m_sc = 0;
   endtask

   // Round rules: 0 idle, 1 play, 2 dead.
   task automatic model_step(input logic u, input logic d, input logic s,
                             input logic c, input logic p);
      if (m_st == 0) begin
         if (s) m_st = 1;
      end else if (m_st == 1) begin
         if (p && SCORE_EN && m_sc < 255) m_sc = m_sc + 1;
         if (c) m_st = 2;
         else if (u) m_y = (m_y - 24 < 0) ? 0 : m_y - 24;
         else if (d) begin
            m_y = (m_y + 4 > 460) ? 460 : m_y + 4;
            if (m_y == 460) m_st = 2;
         end
      end else begin
         if (s) begin m_st = 0; m_y = 240; m_sc = 0; end
      end
   endtask

   task automatic drive(input logic u, input logic d, input logic s,
                        input logic c, input logic p);
      @(negedge clk);
      up_key_press = u; down_key_press = d; start = s; collide = c; pipe_pass = p;
      @(posedge clk);
      model_step(u, d, s, c, p);
      #1;
      up_key_press = 0; down_key_press = 0; start = 0; collide = 0; pipe_pass = 0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      #1;
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
      checks++; if (bird_y !== 10'd240) begin errors++; $display("FAIL rst_y got %0d want 240", bird_y); end
      checks++; if (score !== 8'd0) begin errors++; $display("FAIL rst_score got %0d want 0", score); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL rst_go got %0b want 0", game_over); end
      drive(0, 0, 1, 0, 0);
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_play got %0d want 1", state); end
      repeat (3) drive(0, 1, 0, 0, 0);
      checks++; if (bird_y !== 10'd252) begin errors++; $display("FAIL grav3 got %0d want 252", bird_y); end
   endtask

   task automatic test_ceiling();
      repeat (10) drive(1, 0, 0, 0, 0);
      checks++; if (bird_y !== 10'd12) begin errors++; $display("FAIL flap10 got %0d want 12", bird_y); end
      drive(1, 0, 0, 0, 0);
      checks++; if (bird_y !== 10'd0) begin errors++; $display("FAIL ceil_clamp got %0d want 0", bird_y); end
      drive(1, 0, 0, 0, 0);
      checks++; if (bird_y !== 10'd0 || state !== 2'd1) begin
         errors++; $display("FAIL ceil_hold got y=%0d st=%0d want y=0 st=1", bird_y, state); end
   endtask

   task automatic test_priority();
      repeat (60) drive(0, 1, 0, 0, 0);
      checks++; if (bird_y !== 10'd240) begin errors++; $display("FAIL back240 got %0d want 240", bird_y); end
      drive(1, 1, 0, 0, 0);
      checks++; if (bird_y !== 10'd216) begin errors++; $display("FAIL up_down got %0d want 216", bird_y); end
      drive(1, 0, 0, 1, 0);
      checks++; if (state !== 2'd2 || bird_y !== 10'd216 || game_over !== 1'b1) begin
         errors++; $display("FAIL collide_up got st=%0d y=%0d go=%0b want 2/216/1", state, bird_y, game_over); end
      drive(0, 0, 1, 0, 0);
      checks++; if (state !== 2'd0 || bird_y !== 10'd240 || game_over !== 1'b0) begin
         errors++; $display("FAIL dead_start got st=%0d y=%0d go=%0b want 0/240/0", state, bird_y, game_over); end
      drive(0, 0, 1, 0, 0);
   endtask

   task automatic test_floor();
      repeat (54) drive(0, 1, 0, 0, 0);
      checks++; if (bird_y !== 10'd456 || state !== 2'd1) begin
         errors++; $display("FAIL near_floor got y=%0d st=%0d want 456/1", bird_y, state); end
      drive(0, 1, 0, 0, 0);
      checks++; if (bird_y !== 10'd460 || state !== 2'd2 || game_over !== 1'b1) begin
         errors++; $display("FAIL floor got y=%0d st=%0d go=%0b want 460/2/1", bird_y, state, game_over); end
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0);
      checks++; if (bird_y !== 10'd460 || state !== 2'd2) begin
         errors++; $display("FAIL dead_frozen got y=%0d st=%0d want 460/2", bird_y, state); end
      drive(0, 0, 1, 0, 0);
      drive(0, 0, 1, 0, 0);
   endtask

   task automatic test_score();
      drive(0, 0, 0, 1, 1);
      checks++; if (state !== 2'd2 || score !== 8'(m_sc) || m_sc != (SCORE_EN ? 1 : 0)) begin
         errors++; $display("FAIL pass_collide got st=%0d sc=%0d want 2/%0d", state, score, m_sc); end
      drive(0, 0, 1, 0, 0);
      drive(1, 1, 0, 1, 1);
      checks++; if (state !== 2'd0 || bird_y !== 10'd240 || score !== 8'd0) begin
         errors++; $display("FAIL idle_ignore got st=%0d y=%0d sc=%0d want 0/240/0", state, bird_y, score); end
      drive(0, 0, 1, 0, 0);
      repeat (300) drive(0, 0, 0, 0, 1);
      checks++; if (score !== (SCORE_EN ? 8'd255 : 8'd0) || state !== 2'd1) begin
         errors++; $display("FAIL score_sat got sc=%0d st=%0d want %0d/1", score, state, SCORE_EN ? 255 : 0); end
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 1, 1, 0);
      checks++; if (state !== 2'd0 || score !== 8'd0 || bird_y !== 10'd240) begin
         errors++; $display("FAIL restart_clr got st=%0d sc=%0d y=%0d want 0/0/240", state, score, bird_y); end
      drive(0, 0, 1, 0, 0);
   endtask

   task automatic test_async_reset();
      repeat (6) drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0);
      repeat (5) drive(0, 0, 0, 0, 1);
      checks++; if (bird_y !== 10'd100 || score !== (SCORE_EN ? 8'd5 : 8'd0) || state !== 2'd1) begin
         errors++; $display("FAIL pre_reset got y=%0d sc=%0d st=%0d", bird_y, score, state); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if (state !== 2'd0 || bird_y !== 10'd240 || score !== 8'd0 || game_over !== 1'b0) begin
         errors++; $display("FAIL async_rst got st=%0d y=%0d sc=%0d go=%0b want 0/240/0/0",
                            state, bird_y, score, game_over); end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      drive(0, 0, 1, 0, 0);
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL post_rst_start got %0d want 1", state); end
   endtask

   task automatic test_random();
      logic u, d, s, c, p;
      for (int i = 0; i < 600; i++) begin
         u = ($urandom_range(3) == 0);
         d = ($urandom_range(1) == 0);
         s = ($urandom_range(15) == 0);
         c = ($urandom_range(31) == 0);
         p = ($urandom_range(7) == 0);
         drive(u, d, s, c, p);
         checks++; if (state !== 2'(m_st)) begin errors++; $display("FAIL rnd_state cyc %0d got %0d want %0d", i, state, m_st); end
         checks++; if (bird_y !== 10'(m_y)) begin errors++; $display("FAIL rnd_y cyc %0d got %0d want %0d", i, bird_y, m_y); end
         checks++; if (score !== 8'(m_sc)) begin errors++; $display("FAIL rnd_score cyc %0d got %0d want %0d", i, score, m_sc); end
         checks++; if (game_over !== (m_st == 2)) begin errors++; $display("FAIL rnd_go cyc %0d got %0b want %0b", i, game_over, m_st == 2); end
      end
   endtask

   initial begin
      test_reset();
      test_ceiling();
      test_priority();
      test_floor();
      test_score();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
